// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Shares the single write port of an async FIFO between several producers
// that live in the FIFO write-clock domain. Ownership rotates round-robin,
// and each ownership lasts for at most MAX_BURST words. The owning
// requester is stalled while the FIFO reports full. The grant bit acts as
// the per-cycle ready: requester i's word is consumed in any cycle where
// grant[i] is high.

module fifo_write_arbiter #(
   parameter int NUM_REQUESTERS = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int MAX_BURST      = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQUESTERS-1:0]            request,
   input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] data,
   input  logic                                 fifo_full,
   output logic [NUM_REQUESTERS-1:0]            grant,
   output logic                                 fifo_write_enable,
   output logic [DATA_WIDTH-1:0]                fifo_write_data,
   output logic [$clog2(NUM_REQUESTERS)-1:0]    owner,
   output logic                                 busy
);

   localparam int OW  = $clog2(NUM_REQUESTERS);
   localparam int BCW = $clog2(MAX_BURST + 1);

   // burst_count value at which the current transfer is the final word of the burst
   localparam logic [BCW-1:0] LAST_BEAT  = BCW'(MAX_BURST - 1);
   localparam logic [BCW-1:0] ONE_BEAT   = BCW'(1);
   // last_owner starts at the highest index, so requester 0 is searched first
   localparam logic [OW-1:0]  RESET_LAST = OW'(NUM_REQUESTERS - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t                     state_r;
   logic [OW-1:0]              owner_r;
   logic [OW-1:0]              last_owner_r;
   logic [BCW-1:0]             burst_count_r;

   logic                       owner_req_s;
   logic                       transfer_s;
   logic                       last_beat_s;
   logic [OW-1:0]              rr_pick_s;
   logic [NUM_REQUESTERS-1:0]  grant_s;
   logic [DATA_WIDTH-1:0]      owner_data_s;

   // Finds the first requesting index strictly after 'last', wrapping modulo
   // NUM_REQUESTERS. When no request is set, 'last' is returned unchanged; the
   // caller never uses that result.
   function automatic logic [OW-1:0] rr_pick(
      input logic [NUM_REQUESTERS-1:0] req,
      input logic [OW-1:0]             last
   );
      logic [OW-1:0] pick;
      logic [OW-1:0] cand;
      logic          found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQUESTERS; k++) begin
         cand = OW'((int'(last) + k) % NUM_REQUESTERS);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   // Selects the current owner's request bit and data slice with an AND-OR mux
   always_comb begin
      owner_req_s  = 1'b0;
      owner_data_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         owner_req_s  = owner_req_s | ((owner_r == OW'(i)) & request[i]);
         owner_data_s = owner_data_s |
                        ({DATA_WIDTH{owner_r == OW'(i)}} & data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Transfer qualification; a word moves only in BURST, while the owner requests and the FIFO has room
   always_comb begin
      transfer_s  = (state_r == ST_BURST) & owner_req_s & ~fifo_full;
      last_beat_s = (burst_count_r == LAST_BEAT);
      rr_pick_s   = rr_pick(request, last_owner_r);
   end

   // Per-requester grant; only the owner's bit can be high, and only on a transfer
   always_comb begin
      grant_s = {NUM_REQUESTERS{1'b0}};
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         grant_s[i] = transfer_s & (owner_r == OW'(i));
      end
   end

   // Output drive; write data is forced to zero outside BURST so idle cycles carry no stale word
   always_comb begin
      grant             = grant_s;
      fifo_write_enable = transfer_s;
      if (state_r == ST_BURST) begin
         fifo_write_data = owner_data_s;
      end else begin
         fifo_write_data = {DATA_WIDTH{1'b0}};
      end
      owner = owner_r;
      busy  = (state_r == ST_BURST);
   end

   // Arbitration FSM: IDLE picks the next owner round-robin, BURST counts transferred words
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         owner_r       <= {OW{1'b0}};
         last_owner_r  <= RESET_LAST;
         burst_count_r <= {BCW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|request) begin
                  state_r       <= ST_BURST;
                  owner_r       <= rr_pick_s;
                  last_owner_r  <= rr_pick_s;
                  burst_count_r <= {BCW{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BURST: begin
               if (transfer_s && last_beat_s) begin
                  // final word of the burst has just been written
                  state_r <= ST_IDLE;
               end else if (!owner_req_s) begin
                  // owner withdrew; this also covers full rising in the same cycle
                  state_r <= ST_IDLE;
               end else if (transfer_s) begin
                  burst_count_r <= burst_count_r + ONE_BEAT;
               end else begin
                  // FIFO full while the owner still requests: wait without a timeout
                  burst_count_r <= burst_count_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: queue-driven producers, a FIFO-occupancy
// model, a words-remaining behavioural model compared every cycle, and
// hand-computed expectations for each directed scenario.

module tb_fifo_write_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int MB    = 4;
   localparam int OW    = 2;
   localparam int DEPTH = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [N-1:0]      request = '0;
   logic [N*DW-1:0]   data = '0;
   logic              fifo_full = 1'b0;
   logic [N-1:0]      grant;
   logic              fifo_write_enable;
   logic [DW-1:0]     fifo_write_data;
   logic [OW-1:0]     owner;
   logic              busy;

   fifo_write_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .request(request), .data(data), .fifo_full(fifo_full),
      .grant(grant), .fifo_write_enable(fifo_write_enable), .fifo_write_data(fifo_write_data),
      .owner(owner), .busy(busy)
   );

   // 10 ns write clock
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] src_q [N][$];
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] rd_log[$];
   int            wr_owner[$];
   logic [DW-1:0] wr_data[$];
   int            wr_cyc[$];
   int            wr_count = 0;
   int            cyc = 0;
   logic [N-1:0]  gnt_seen = '0;
   bit            full_force = 1'b0;
   bit            drain_en = 1'b0;
   int            drain_div = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int wo(input int j);
      return (j < wr_owner.size()) ? wr_owner[j] : -1;
   endfunction
   function automatic int wd(input int j);
      return (j < wr_data.size()) ? int'(wr_data[j]) : -1;
   endfunction
   function automatic int wc(input int j);
      return (j < wr_cyc.size()) ? wr_cyc[j] : -1;
   endfunction
   function automatic int rd(input int j);
      return (j < rd_log.size()) ? int'(rd_log[j]) : -1;
   endfunction

   // Drives request/data from the producer queues and fifo_full from the FIFO model
   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         request[i] = (src_q[i].size() > 0);
         data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
      fifo_full = full_force || (fifo_q.size() >= DEPTH);
   endtask

   // One clock: consume granted words, drain the FIFO slowly, then re-drive inputs
   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++)
         if (gnt_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      gnt_seen = '0;
      if (drain_en) begin
         drain_div++;
         if ((drain_div % 4) == 0 && fifo_q.size() > 0) rd_log.push_back(fifo_q.pop_front());
      end
      refresh();
   endtask

   task automatic wait_writes(input int target, input int budget, input string name);
      int n = 0;
      while (wr_count < target && n < budget) begin
         cycle();
         n++;
      end
      chk(name, 64'(wr_count >= target), 64'd1);
   endtask

   // Behavioural model: busy flag, owner, last owner and words left in the burst
   bit m_busy;
   int m_owner, m_last, m_left;

   function automatic int rr_next(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++)
         if (req[(last + k) % N]) return (last + k) % N;
      return last;
   endfunction

   // Model state advance on every write-clock edge
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0; m_owner <= 0; m_last <= N - 1; m_left <= 0;
      end else if (!m_busy) begin
         if (request != '0) begin
            m_busy  <= 1'b1;
            m_owner <= rr_next(request, m_last);
            m_last  <= rr_next(request, m_last);
            m_left  <= MB;
         end
      end else if (!request[m_owner]) begin
         m_busy <= 1'b0;
      end else if (!fifo_full) begin
         m_left <= m_left - 1;
         if (m_left == 1) m_busy <= 1'b0;
      end
   end

   bit            x_xfer;
   logic [DW-1:0] x_data;
   // Per-cycle comparison against the model, plus write logging and FIFO push
   always @(negedge clk) begin
      if (reset) begin
         x_xfer = m_busy && request[m_owner] && !fifo_full;
         x_data = m_busy ? DW'(data >> (m_owner * DW)) : 8'h00;
         chk("grant", 64'(grant), x_xfer ? (64'd1 << m_owner) : 64'd0);
         chk("write_enable", 64'(fifo_write_enable), 64'(x_xfer));
         chk("write_data", 64'(fifo_write_data), 64'(x_data));
         chk("owner", 64'(owner), 64'(m_owner));
         chk("busy", 64'(busy), 64'(m_busy));
         chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
         if (fifo_write_enable) begin
            wr_owner.push_back(int'(owner));
            wr_data.push_back(fifo_write_data);
            wr_cyc.push_back(cyc);
            wr_count++;
            if (drain_en) begin
               fifo_q.push_back(fifo_write_data);
               chk("fifo_no_overflow", 64'(fifo_q.size() <= DEPTH), 64'd1);
            end
         end
         gnt_seen = grant;
      end
   end

   initial begin
      int base;
      int c0;
      int n;

      // Reset held with random inputs: every output must read zero
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         request   = N'($urandom);
         data      = $urandom;
         fifo_full = 1'($urandom);
         #1;
         chk("rst_grant", 64'(grant), 64'd0);
         chk("rst_we", 64'(fifo_write_enable), 64'd0);
         chk("rst_wd", 64'(fifo_write_data), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_owner", 64'(owner), 64'd0);
      end
      refresh();
      @(negedge clk);
      #2 reset = 1'b1;

      // Requesters 0 and 2 together: 0 first, bubble, then 2
      for (int k = 0; k < 4; k++) begin
         src_q[0].push_back(8'h10 + 8'(k));
         src_q[2].push_back(8'h30 + 8'(k));
      end
      refresh();
      c0 = cyc;
      wait_writes(8, 40, "t1_wait");
      for (int j = 0; j < 8; j++) begin
         chk("t1_owner", 64'(wo(j)), (j < 4) ? 64'd0 : 64'd2);
         chk("t1_data", 64'(wd(j)), (j < 4) ? 64'(8'h10 + j) : 64'(8'h30 + j - 4));
      end
      chk("t1_latency", 64'(wc(0)), 64'(c0 + 1));
      chk("t1_bubble", 64'(wc(4) - wc(3)), 64'd2);

      // Fairness: fresh reset, all four requesting for 20 cycles
      cycle();
      #1 reset = 1'b0;
      #1 reset = 1'b1;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 8; k++) src_q[i].push_back(8'h40 + 8'(i * 16 + k));
      refresh();
      base = wr_count;
      repeat (20) cycle();
      for (int i = 0; i < N; i++) src_q[i].delete();
      refresh();
      repeat (3) cycle();
      chk("rr_writes", 64'(wr_count - base), 64'd16);
      for (int j = 0; j < 16; j++) begin
         chk("rr_owner", 64'(wo(base + j)), 64'(j / 4));
         chk("rr_data", 64'(wd(base + j)), 64'(8'h40 + (j / 4) * 16 + (j % 4)));
      end

      // Backpressure: full for 3 cycles after the 2nd write
      for (int k = 0; k < 4; k++) src_q[0].push_back(8'h50 + 8'(k));
      refresh();
      base = wr_count;
      wait_writes(base + 2, 20, "bp_wait2");
      full_force = 1'b1;
      refresh();
      repeat (3) cycle();
      chk("bp_hold", 64'(wr_count - base), 64'd2);
      chk("bp_count", 64'(dut.burst_count_r), 64'd2);
      full_force = 1'b0;
      refresh();
      wait_writes(base + 4, 20, "bp_wait4");
      repeat (3) cycle();
      chk("bp_total", 64'(wr_count - base), 64'd4);
      chk("bp_word3", 64'(wd(base + 2)), 64'h52);
      chk("bp_word4", 64'(wd(base + 3)), 64'h53);

      // Early withdrawal: requester 1 has a single word, requester 3 waits
      src_q[1].push_back(8'h61);
      for (int k = 0; k < 4; k++) src_q[3].push_back(8'h70 + 8'(k));
      refresh();
      base = wr_count;
      wait_writes(base + 5, 30, "wd_wait");
      repeat (2) cycle();
      chk("wd_total", 64'(wr_count - base), 64'd5);
      chk("wd_owner1", 64'(wo(base)), 64'd1);
      chk("wd_data1", 64'(wd(base)), 64'h61);
      chk("wd_owner3", 64'(wo(base + 1)), 64'd3);
      chk("wd_gap", 64'(wc(base + 1) - wc(base)), 64'd3);

      // Async reset during the 3rd write of requester 1
      for (int k = 0; k < 4; k++) src_q[1].push_back(8'h80 + 8'(k));
      refresh();
      base = wr_count;
      wait_writes(base + 2, 20, "ar_wait2");
      chk("ar_owner_before", 64'(owner), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_grant", 64'(grant), 64'd0);
      chk("ar_we", 64'(fifo_write_enable), 64'd0);
      chk("ar_wd", 64'(fifo_write_data), 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_owner", 64'(owner), 64'd0);
      src_q[0].push_back(8'h90);
      src_q[0].push_back(8'h91);
      refresh();
      @(negedge clk);
      #2 reset = 1'b1;
      chk("ar_no_write", 64'(wr_count - base), 64'd2);
      wait_writes(base + 6, 40, "ar_wait6");
      chk("ar_first_owner", 64'(wo(base + 2)), 64'd0);
      chk("ar_first_data", 64'(wd(base + 2)), 64'h90);
      chk("ar_resume_data", 64'(wd(base + 4)), 64'h82);

      // Integration with a depth-8 FIFO drained slowly
      repeat (3) cycle();
      drain_en = 1'b1;
      for (int k = 0; k < 6; k++) fifo_q.push_back(8'hE0 + 8'(k));
      for (int k = 0; k < 4; k++) begin
         src_q[0].push_back(8'hA0 + 8'(k));
         src_q[1].push_back(8'hB0 + 8'(k));
      end
      refresh();
      n = 0;
      while (rd_log.size() < 14 && n < 400) begin
         cycle();
         n++;
      end
      chk("fifo_reads", 64'(rd_log.size()), 64'd14);
      for (int j = 0; j < 8; j++)
         chk("fifo_order", 64'(rd(6 + j)), (j < 4) ? 64'(8'hA0 + j) : 64'(8'hB0 + j - 4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
